icmp_echo_tx: RTL
=================

Name: icmp_echo_tx

Overview:
Builds and serialises an ICMP echo reply from a validated echo request frame. It is the transmit counterpart of the ICMP receive parser. It accepts one request frame per handshake and rewrites addresses and type. It recomputes the IPv4 header checksum and the ICMP checksum serially. It then streams the reply byte-wise to the Ethernet MAC as a contiguous valid burst.

Parameters:
FRM_BYTES, 74, total frame bytes (14 Ethernet + 20 IPv4 + ICMP); must equal the package ICMP frame size; legal 42..255
REPLY_TTL, 64, IPv4 TTL written into the reply
IFG_CYCLES, 12, minimum idle cycles with mac_valid_o low after each frame

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
hw_addr_i  in  48  local MAC address
ip_addr_i  in  32  local IPv4 address
req_frame_i  in  8*FRM_BYTES  request frame; byte 0 (dst MAC MSB) in bits [8*FRM_BYTES-1 -: 8]
req_valid_i  in  1  request frame valid
req_ready_o  out  1  block idle, can accept
mac_data_o  out  8  reply byte
mac_valid_o  out  1  reply byte valid
tx_done_o  out  1  one-cycle pulse coincident with last reply byte

Behaviour:
- Reset values: req_ready_o=1, mac_data_o=0, mac_valid_o=0, tx_done_o=0, state=IDLE, all counters and accumulators 0. Async reset mid-frame aborts immediately. No partial frame resumes.
- Handshake: the request is accepted on a rising edge with req_valid_i & req_ready_o. req_ready_o is high only in IDLE. A request while busy is ignored and not queued.
- Reply construction is captured into an FRM_BYTES shift register at acceptance, using frame byte offsets:
  - 0-5 = req 6-11 (src MAC becomes dst)
  - 6-11 = hw_addr_i
  - 12-13 = 0x0800
  - 14-21 copied (ver/IHL, TOS, total length, ID, flags/frag)
  - 22 = REPLY_TTL
  - 23 = 0x01
  - 24-25 = 0 (filled later)
  - 26-29 = ip_addr_i
  - 30-33 = req 26-29
  - 34 = 0x00 (type echo reply)
  - 35 = 0x00
  - 36-37 = 0 (filled later)
  - 38..FRM_BYTES-1 copied (ID, seq, payload)
- Checksum rule: one's-complement 16-bit sum over big-endian words with the checksum field zero. Carry is folded back each cycle (17-bit accumulator). The result is inverted.
  - IP covers bytes 14-33 (10 words).
  - ICMP covers bytes 34..FRM_BYTES-1, ICMP_WORDS=ceil((FRM_BYTES-34)/2); an odd trailing byte is padded with 0x00 as the low byte.
  - One IP word and one ICMP word are added per cycle, in parallel.
  - Config inputs are sampled only at acceptance; later changes do not affect the frame in flight.
- FSM:
  - IDLE: accept -> CKSUM.
  - CKSUM: CK_CYC=max(10,ICMP_WORDS) cycles; word counter 0..CK_CYC-1; each sum stops at its own word count -> FINAL.
  - FINAL: 1 cycle; final fold and invert; write bytes 24-25 and 36-37 -> TX.
  - TX: FRM_BYTES cycles; one byte per cycle MSB-first (shift left by 8); byte counter 0..FRM_BYTES-1; tx_done_o=1 with byte FRM_BYTES-1 -> GAP.
  - GAP: IFG_CYCLES cycles, outputs low -> IDLE.
- Latency: mac_valid_o first high exactly CK_CYC+2 cycles after the acceptance edge. It stays high for exactly FRM_BYTES consecutive cycles with no gaps (no backpressure). mac_data_o=0 whenever mac_valid_o=0.
- Minimum request-to-request spacing is CK_CYC+2+FRM_BYTES+IFG_CYCLES cycles. req_ready_o rises on the cycle after GAP completes.
- The block does no validation of the request. The upstream parser guarantees it is an echo request addressed to this node.

Test Plan:
- Basic reply, default params:
  - Stimulus: hw 02:00:00:00:00:01, ip C0A8010A; request from 02:00:00:00:00:02 / C0A80114, ID 0x1234, seq 0x0001, TTL 128, payload 0x61..0x80.
  - Response: 74 contiguous bytes beginning 02 00 00 00 00 02 02 00 00 00 00 01 08 00; byte22=0x40, byte34=0x00; IP and ICMP sum over reply = 0xFFFF.
  - Response: reply ICMP checksum = request checksum + 0x0800 (one's complement).
- Latency:
  - Stimulus: accept at edge N (CK_CYC=20).
  - Response: mac_valid_o rises at edge N+22, falls after N+95; tx_done_o only at N+95; req_ready_o low until GAP completes.
- Busy drop:
  - Stimulus: second req_valid_i pulse during TX with a different seq.
  - Response: ignored; exactly one frame out; the next frame is accepted only after IFG_CYCLES.
- Odd length:
  - Stimulus: FRM_BYTES=75, payload last byte 0xFF.
  - Response: the ICMP checksum treats 0xFF00 as the final word, matching the model.
- Reset:
  - Stimulus: assert rst at byte 30 of TX.
  - Response: mac_valid_o=0 immediately, req_ready_o=1 after release; the next request produces a complete, correct frame.
- Config sampling:
  - Stimulus: change ip_addr_i during CKSUM.
  - Response: the reply carries the value present at acceptance.

Source files
------------

// File: rtl/icmp_echo_tx.sv
// ICMP echo reply transmitter: rewrites a captured echo request into a reply,
// recomputes both checksums word-serially and streams the frame to the MAC.
module icmp_echo_tx #(
    parameter int FRM_BYTES  = 74,
    parameter int REPLY_TTL  = 64,
    parameter int IFG_CYCLES = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [47:0]            hw_addr_i,
    input  logic [31:0]            ip_addr_i,
    input  logic [8*FRM_BYTES-1:0] req_frame_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    output logic [7:0]             mac_data_o,
    output logic                   mac_valid_o,
    output logic                   tx_done_o
);
    localparam int FW         = 8 * FRM_BYTES;
    localparam int ICMP_WORDS = (FRM_BYTES - 33) / 2;
    localparam int CK_CYC     = (ICMP_WORDS > 10) ? ICMP_WORDS : 10;

    localparam logic [7:0]  TTL_BYTE  = 8'(REPLY_TTL);
    localparam logic [15:0] CK_LAST   = 16'(CK_CYC - 1);
    localparam logic [15:0] TX_LAST   = 16'(FRM_BYTES - 1);
    localparam logic [15:0] GAP_LAST  = 16'(IFG_CYCLES - 1);
    localparam logic [15:0] ICMP_W16  = 16'(ICMP_WORDS);
    localparam logic [15:0] TAIL_IDX  = 16'(ICMP_WORDS - 1);

    typedef enum logic [2:0] {IDLE, CKSUM, FINAL, TX, GAP} state_t;

    state_t          state_q, state_d;
    logic [FW-1:0]   frame_q, frame_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [16:0]     ip_acc_q, ip_acc_d;
    logic [16:0]     icmp_acc_q, icmp_acc_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            done_q, done_d;

    logic            accept;
    logic [FW-1:0]   reply_init;
    logic [15:0]     ip_word, icmp_word, tail_word;
    logic [15:0]     ip_ck, icmp_ck;

    function automatic logic [15:0] fold_invert(input logic [16:0] acc);
        logic [16:0] s;
        s = {1'b0, acc[15:0]} + {16'b0, acc[16]};
        return ~(s[15:0] + {15'b0, s[16]});
    endfunction

    assign accept      = req_valid_i && (state_q == IDLE);
    assign ip_ck       = fold_invert(ip_acc_q);
    assign icmp_ck     = fold_invert(icmp_acc_q);
    assign req_ready_o = (state_q == IDLE);
    assign mac_data_o  = data_q;
    assign mac_valid_o = valid_q;
    assign tx_done_o   = done_q;

    // An odd frame length pads the last ICMP word with a zero low byte
    if (FRM_BYTES % 2 == 1) begin : g_odd
        assign tail_word = {frame_q[7:0], 8'h00};
    end else begin : g_even
        assign tail_word = frame_q[15:0];
    end

    always_comb begin
        reply_init               = req_frame_i;
        reply_init[FW-1 -: 48]   = req_frame_i[FW-49 -: 48];
        reply_init[FW-49 -: 48]  = hw_addr_i;
        reply_init[FW-97 -: 16]  = 16'h0800;
        reply_init[FW-177 -: 8]  = TTL_BYTE;
        reply_init[FW-185 -: 8]  = 8'h01;
        reply_init[FW-193 -: 16] = 16'h0000;
        reply_init[FW-209 -: 32] = ip_addr_i;
        reply_init[FW-241 -: 32] = req_frame_i[FW-209 -: 32];
        reply_init[FW-273 -: 32] = 32'h0000_0000;
    end

    always_comb begin
        ip_word   = 16'h0000;
        icmp_word = tail_word;
        for (int i = 0; i < 10; i++)
            if (cnt_q == 16'(i)) ip_word = frame_q[FW-8*(14+2*i)-1 -: 16];
        for (int i = 0; i < ICMP_WORDS - 1; i++)
            if (cnt_q == 16'(i)) icmp_word = frame_q[FW-8*(34+2*i)-1 -: 16];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            frame_q    <= '0;
            cnt_q      <= '0;
            ip_acc_q   <= '0;
            icmp_acc_q <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            cnt_q      <= cnt_d;
            ip_acc_q   <= ip_acc_d;
            icmp_acc_q <= icmp_acc_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = CKSUM;
            CKSUM:   if (cnt_q == CK_LAST) state_d = FINAL;
            FINAL:   state_d = TX;
            TX:      if (cnt_q == TX_LAST) state_d = GAP;
            GAP:     if (cnt_q == GAP_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered, so each byte appears one cycle after its TX slot
    always_comb begin
        frame_d    = frame_q;
        cnt_d      = cnt_q;
        ip_acc_d   = ip_acc_q;
        icmp_acc_d = icmp_acc_q;
        data_d     = 8'h00;
        valid_d    = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    frame_d    = reply_init;
                    cnt_d      = '0;
                    ip_acc_d   = '0;
                    icmp_acc_d = '0;
                end
            end
            CKSUM: begin
                if (cnt_q < 16'd10)
                    ip_acc_d = {1'b0, ip_acc_q[15:0]} + {16'b0, ip_acc_q[16]} + {1'b0, ip_word};
                if (cnt_q < ICMP_W16)
                    icmp_acc_d = {1'b0, icmp_acc_q[15:0]} + {16'b0, icmp_acc_q[16]}
                               + {1'b0, (cnt_q == TAIL_IDX) ? tail_word : icmp_word};
                cnt_d = (cnt_q == CK_LAST) ? 16'd0 : cnt_q + 16'd1;
            end
            FINAL: begin
                frame_d[FW-193 -: 16] = ip_ck;
                frame_d[FW-289 -: 16] = icmp_ck;
            end
            TX: begin
                data_d  = frame_q[FW-1 -: 8];
                valid_d = 1'b1;
                done_d  = (cnt_q == TX_LAST);
                frame_d = frame_q << 8;
                cnt_d   = (cnt_q == TX_LAST) ? 16'd0 : cnt_q + 16'd1;
            end
            GAP: begin
                cnt_d = (cnt_q == GAP_LAST) ? 16'd0 : cnt_q + 16'd1;
            end
            default: ;
        endcase
    end
endmodule
